// File: rtl/store_buffer_if.sv
// Bundles the signals between the store buffer, the pipeline and the data memory.
// Handshakes: a store transfers on a cycle where st_valid && st_ready are both high.
// A load is serviced on a cycle where ld_valid && !ld_stall; otherwise the pipeline
// holds ld_valid and its fields stable.
interface store_buffer_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH + 1);

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_size;
  logic          st_ready;

  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [2:0]    ld_size;
  logic          ld_stall;
  logic [31:0]   ld_data;

  logic [31:0]   mem_access_addr;
  logic [31:0]   mem_wr_val;
  logic          mem_write_en;
  logic          mem_read_en;
  logic [2:0]    mem_data_size;
  logic [31:0]   mem_rd_val;

  logic [CW-1:0] count;
  logic          empty;

  // Pipeline and memory side (drives requests and read data).
  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size, mem_rd_val,
    input  st_ready, ld_stall, ld_data, mem_access_addr, mem_wr_val, mem_write_en,
           mem_read_en, mem_data_size, count, empty
  );

  // Store buffer side.
  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size, mem_rd_val,
    output st_ready, ld_stall, ld_data, mem_access_addr, mem_wr_val, mem_write_en,
           mem_read_en, mem_data_size, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: queues committed stores in a FIFO and drains them in order to the
// data memory write port. Loads get the memory port combinationally unless an
// older buffered store overlaps their byte range, or the buffer is full.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Entry storage; validity is derived from head/count, so it needs no reset.
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [2:0]    size_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          is_empty;
  logic          push;
  logic          pop;
  logic          hazard;
  logic [PW-1:0] off_v [DEPTH];
  logic [DEPTH-1:0] entry_valid;

  logic          drain;
  logic          rd_en;
  logic          wr_en;
  logic [31:0]   acc_addr;
  logic [31:0]   wr_val;
  logic [2:0]    acc_size;
  logic [31:0]   ld_data;
  logic          ld_stall;

  // Access length in bytes; codes other than byte/half are treated as word.
  function automatic logic [32:0] byte_len(input logic [2:0] size);
    case (size[1:0])
      2'b00:   byte_len = 33'd1;
      2'b01:   byte_len = 33'd2;
      default: byte_len = 33'd4;
    endcase
  endfunction

  // Inclusive byte ranges in 33 bits so an access near 0xFFFFFFFF never wraps to 0.
  function automatic logic ranges_overlap(input logic [31:0] a, input logic [2:0] sa,
                                          input logic [31:0] b, input logic [2:0] sb);
    logic [32:0] a_lo, a_hi, b_lo, b_hi;
    a_lo = {1'b0, a};
    a_hi = a_lo + byte_len(sa) - 33'd1;
    b_lo = {1'b0, b};
    b_hi = b_lo + byte_len(sb) - 33'd1;
    ranges_overlap = (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign push     = bus.st_valid && !full && !reset;
  assign pop      = drain;

  // Mark entries between head and head+count as live, then check them against the load.
  always_comb begin
    hazard      = 1'b0;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_v[i]       = PW'(i) - head_q;
      entry_valid[i] = (CW'(off_v[i]) < count_q);
      if (entry_valid[i] &&
          ranges_overlap(addr_q[i], size_q[i], bus.ld_addr, bus.ld_size)) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && bus.ld_valid;
  end

  // Memory port arbitration: full drain, then clean load, then opportunistic drain.
  always_comb begin
    drain    = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    acc_addr = '0;
    wr_val   = '0;
    acc_size = '0;
    ld_data  = '0;
    ld_stall = 1'b0;
    if (!reset) begin
      if (full) begin
        drain    = 1'b1;
        ld_stall = bus.ld_valid;
      end else if (bus.ld_valid && !hazard) begin
        rd_en    = 1'b1;
        acc_addr = bus.ld_addr;
        acc_size = bus.ld_size;
        ld_data  = bus.mem_rd_val;
      end else if (!is_empty) begin
        drain    = 1'b1;
        ld_stall = bus.ld_valid;
      end
      if (drain) begin
        wr_en    = 1'b1;
        acc_addr = addr_q[head_q];
        wr_val   = data_q[head_q];
        acc_size = size_q[head_q];
      end
    end
  end

  // Next pointer and occupancy values.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Pointer and count registers; reset discards every queued store.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Capture an accepted store into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
      size_q[tail_q] <= bus.st_size;
    end
  end

  assign bus.st_ready        = !full;
  assign bus.count           = count_q;
  assign bus.empty           = is_empty;
  assign bus.mem_read_en     = rd_en;
  assign bus.mem_write_en    = wr_en;
  assign bus.mem_access_addr = acc_addr;
  assign bus.mem_wr_val      = wr_val;
  assign bus.mem_data_size   = acc_size;
  assign bus.ld_data         = ld_data;
  assign bus.ld_stall        = ld_stall;
endmodule
